// File: rtl/stack_memory_responder.sv
// ============================================================================
// Module   : stack_memory_responder
// Brief    : Word-addressed data/stack RAM with region and privilege checks,
//            one request at a time, valid/ready response channel.
//            Optional fault latch: STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_memory_responder #(
  parameter int unsigned ADDR_WIDTH            = 14,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned CODE_AREA_SIZE        = 4096,
  parameter int unsigned PRIVILEGED_STACK_SIZE = 2048,
  parameter int unsigned USER_STACK_SIZE       = 2048,
  parameter int unsigned DATA_AREA_SIZE        = 8192
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            control_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  write_enable_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  privilege_mode_flag_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  fault_o,
  output logic [1:0]            fault_code_o
`ifdef STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
  ,
  output logic                  fault_sticky_o,
  output logic [ADDR_WIDTH-1:0] fault_address_o
`endif
);

  localparam int unsigned MEM_AW = $clog2(DATA_AREA_SIZE);

  localparam logic [31:0] PRIV_LO  = 32'(CODE_AREA_SIZE);
  localparam logic [31:0] PRIV_HI  = 32'(CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE);
  localparam logic [31:0] USER_HI  = 32'(CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE + USER_STACK_SIZE);
  localparam logic [31:0] DATA_TOP = 32'(DATA_AREA_SIZE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [1:0] CTRL_LS   = 2'd0;
  localparam logic [1:0] CTRL_PUSH = 2'd1;
  localparam logic [1:0] CTRL_POP  = 2'd2;
  localparam logic [1:0] CTRL_RSVD = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  priv_q, priv_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  fault_q, fault_d;
  logic [1:0]            fault_code_q, fault_code_d;

  logic [DATA_WIDTH-1:0] mem_q [DATA_AREA_SIZE];

  logic [31:0]       addr_ext;
  logic [MEM_AW-1:0] mem_idx;
  logic              is_store, is_load, is_push, is_pop;
  logic              in_priv, in_user, in_active;
  logic [1:0]        code_w;
  logic              mem_we;

  assign addr_ext = 32'(addr_q);
  assign mem_idx  = addr_q[MEM_AW-1:0];

  assign is_store  = (ctrl_q == CTRL_LS) && we_q;
  assign is_load   = (ctrl_q == CTRL_LS) && !we_q;
  assign is_push   = (ctrl_q == CTRL_PUSH);
  assign is_pop    = (ctrl_q == CTRL_POP);
  assign in_priv   = (addr_ext >= PRIV_LO) && (addr_ext < PRIV_HI);
  assign in_user   = (addr_ext >= PRIV_HI) && (addr_ext < USER_HI);
  assign in_active = priv_q ? in_priv : in_user;

  // Checks are ordered by priority: range, then stack/privilege, then code write.
  always_comb begin
    code_w = 2'd0;
    if ((ctrl_q == CTRL_RSVD) || (addr_ext >= DATA_TOP)) begin
      code_w = 2'd3;
    end else if (((is_push || is_pop) && !in_active) || (!priv_q && in_priv)) begin
      code_w = 2'd2;
    end else if ((is_store || is_push) && (addr_ext < PRIV_LO)) begin
      code_w = 2'd1;
    end
  end

  // Gated by the async-reset state register, so reset in ACCESS kills the write.
  assign mem_we = (state_q == S_ACCESS) && (code_w == 2'd0) && (is_store || is_push);

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_valid_i) state_d = S_ACCESS;
      S_ACCESS:  state_d = S_RESPOND;
      S_RESPOND: if (resp_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_RESPOND);
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    priv_d       = priv_q;
    read_data_d  = read_data_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    if ((state_q == S_IDLE) && req_valid_i) begin
      ctrl_d  = control_i;
      addr_d  = address_i;
      we_d    = write_enable_i;
      wdata_d = write_data_i;
      priv_d  = privilege_mode_flag_i;
    end
    if (state_q == S_ACCESS) begin
      fault_code_d = code_w;
      fault_d      = (code_w != 2'd0);
      read_data_d  = ((code_w == 2'd0) && (is_load || is_pop)) ? mem_q[mem_idx] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q       <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      priv_q       <= 1'b0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'd0;
    end else begin
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      priv_q       <= priv_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign read_data_o  = read_data_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;

`ifdef STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
  logic                  sticky_q, sticky_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;

  // Only the first fault after reset is recorded.
  always_comb begin
    sticky_d = sticky_q;
    faddr_d  = faddr_q;
    if ((state_q == S_ACCESS) && (code_w != 2'd0) && !sticky_q) begin
      sticky_d = 1'b1;
      faddr_d  = addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= 1'b0;
      faddr_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      faddr_q  <= faddr_d;
    end
  end

  assign fault_sticky_o  = sticky_q;
  assign fault_address_o = faddr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_memory_responder.sv
// ============================================================================
// Module   : tb_stack_memory_responder
// Brief    : Directed scoreboard bench for stack_memory_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stack_memory_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  control_i;
  logic [13:0] address_i;
  logic        write_enable_i;
  logic [31:0] write_data_i;
  logic        privilege_mode_flag_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] read_data_o;
  logic        fault_o;
  logic [1:0]  fault_code_o;
`ifdef STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
  logic        fault_sticky_o;
  logic [13:0] fault_address_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] data;
    logic        f;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  stack_memory_responder dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .req_valid_i           (req_valid_i),
    .req_ready_o           (req_ready_o),
    .control_i             (control_i),
    .address_i             (address_i),
    .write_enable_i        (write_enable_i),
    .write_data_i          (write_data_i),
    .privilege_mode_flag_i (privilege_mode_flag_i),
    .resp_valid_o          (resp_valid_o),
    .resp_ready_i          (resp_ready_i),
    .read_data_o           (read_data_o),
    .fault_o               (fault_o),
    .fault_code_o          (fault_code_o)
`ifdef STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
    ,
    .fault_sticky_o        (fault_sticky_o),
    .fault_address_o       (fault_address_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller is positioned 1 time unit after a rising edge with the DUT idle.
  task automatic txn(input logic [1:0] ctrl, input logic [13:0] addr, input logic we,
                     input logic [31:0] wd, input logic priv, input logic chk_data,
                     input logic [31:0] ed, input logic ef, input logic [1:0] ec,
                     input int hold, output logic [31:0] rd_obs);
    exp_t e;
    int   n;
    check("req_ready_idle", 64'(req_ready_o), 64'd1);
    control_i             = ctrl;
    address_i             = addr;
    write_enable_i        = we;
    write_data_i          = wd;
    privilege_mode_flag_i = priv;
    req_valid_i           = 1'b1;
    resp_ready_i          = (hold == 0);
    sb.push_back('{chk_data: chk_data, data: ed, f: ef, code: ec});
    @(posedge clk_i); #1;
    req_valid_i    = 1'b0;
    address_i      = ~addr;
    write_data_i   = ~wd;
    write_enable_i = ~we;
    check("accept_busy", 64'({req_ready_o, resp_valid_o}), 64'd0);
    n = 1;
    while (!resp_valid_o && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("latency", 64'(n), 64'd2);
    e = sb.pop_front();
    rd_obs = read_data_o;
    if (e.chk_data) check("read_data", 64'(read_data_o), 64'(e.data));
    check("fault", 64'({fault_o, fault_code_o}), 64'({e.f, e.code}));
    for (int i = 0; i < hold; i++) begin
      check("hold_state", 64'({resp_valid_o, req_ready_o, read_data_o}), 64'({1'b1, 1'b0, rd_obs}));
      req_valid_i = ~req_valid_i;
      address_i   = 14'd6300 + 14'(i);
      control_i   = 2'd1;
      @(posedge clk_i); #1;
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("release", 64'({resp_valid_o, req_ready_o}), 64'b01);
  endtask

  logic [31:0] rd;
  int          seen;

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    control_i = 2'd0;
    address_i = '0;
    write_enable_i = 1'b0;
    write_data_i = '0;
    privilege_mode_flag_i = 1'b0;
    resp_ready_i = 1'b1;
    #1;
    check("reset_state", 64'({req_ready_o, resp_valid_o, read_data_o, fault_o, fault_code_o}),
          64'({1'b1, 1'b0, 32'd0, 1'b0, 2'd0}));
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // user push / pop
    txn(2'd1, 14'd6200, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 32'd0, 1'b0, 2'd0, 0, rd);
    txn(2'd2, 14'd6200, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 0, rd);

    // privileged stack
    txn(2'd1, 14'd4500, 1'b0, 32'h12345678, 1'b1, 1'b1, 32'd0, 1'b0, 2'd0, 0, rd);
    txn(2'd0, 14'd4500, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, 2'd2, 0, rd);
    txn(2'd0, 14'd4500, 1'b0, 32'h0, 1'b1, 1'b1, 32'h12345678, 1'b0, 2'd0, 0, rd);

    // code-area store blocked; load from code area allowed
    txn(2'd0, 14'd100, 1'b1, 32'h55, 1'b0, 1'b1, 32'd0, 1'b1, 2'd1, 0, rd);
    txn(2'd0, 14'd100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 0, rd);
    check("code_not_written", 64'(rd !== 32'h55), 64'd1);

    // range / reserved / priority
    txn(2'd0, 14'd8192, 1'b0, 32'h0, 1'b1, 1'b1, 32'd0, 1'b1, 2'd3, 0, rd);
    txn(2'd3, 14'd5000, 1'b0, 32'h0, 1'b1, 1'b1, 32'd0, 1'b1, 2'd3, 0, rd);
    txn(2'd1, 14'd100, 1'b0, 32'hAA, 1'b1, 1'b1, 32'd0, 1'b1, 2'd2, 0, rd);
    txn(2'd2, 14'd5000, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, 2'd2, 0, rd);

    // backpressure: held response, toggling req_valid must not capture
    txn(2'd2, 14'd6200, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 5, rd);
    txn(2'd2, 14'd6300, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 0, rd);
    txn(2'd0, 14'd6200, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 2'd0, 0, rd);

    // reset during ACCESS suppresses the write
    txn(2'd1, 14'd7000, 1'b0, 32'h70007000, 1'b0, 1'b1, 32'd0, 1'b0, 2'd0, 0, rd);
    control_i = 2'd0; address_i = 14'd7000; write_enable_i = 1'b1;
    write_data_i = 32'hBADBAD00; privilege_mode_flag_i = 1'b0; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("store_in_access", 64'(req_ready_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    check("async_reset", 64'({req_ready_o, resp_valid_o, read_data_o, fault_o, fault_code_o}),
          64'({1'b1, 1'b0, 32'd0, 1'b0, 2'd0}));
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid_o) seen++;
      @(posedge clk_i); #1;
    end
    check("no_resp_after_reset", 64'(seen), 64'd0);
    txn(2'd0, 14'd7000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h70007000, 1'b0, 2'd0, 0, rd);

`ifdef STACK_MEMORY_RESPONDER_FAULT_LATCH_EN
    rst_ni = 1'b0; #1;
    check("latch_reset", 64'({fault_sticky_o, fault_address_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    txn(2'd0, 14'd9000, 1'b0, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1, 2'd3, 0, rd);
    txn(2'd1, 14'd100, 1'b0, 32'h1, 1'b0, 1'b1, 32'd0, 1'b1, 2'd2, 0, rd);
    check("latch_first", 64'({fault_sticky_o, fault_address_o}), 64'({1'b1, 14'd9000}));
    rst_ni = 1'b0; #1;
    check("latch_cleared", 64'({fault_sticky_o, fault_address_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stack_memory_responder.md
Name: stack_memory_responder

Overview:
- Memory-side responder for the data/stack address stream produced by the CPU's address-handling logic.
- Accepts one request at a time (load, store, push, pop) and performs region and privilege checks.
- Accesses an internal word-addressed RAM and returns read data or a fault code over a valid/ready response channel.
- Sits between the address handler and the data-memory port of the core.

Parameters:
ADDR_WIDTH, 14, word-address width
DATA_WIDTH, 32, data word width
CODE_AREA_SIZE, 4096, words [0, CODE_AREA_SIZE) are code area, write-protected
PRIVILEGED_STACK_SIZE, 2048, privileged stack occupies [CODE_AREA_SIZE, CODE_AREA_SIZE+PRIVILEGED_STACK_SIZE)
USER_STACK_SIZE, 2048, user stack occupies the next USER_STACK_SIZE words
DATA_AREA_SIZE, 8192, RAM depth; addresses >= DATA_AREA_SIZE are invalid

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
control  in  2  0 = load/store, 1 = push, 2 = pop, 3 = reserved
address  in  ADDR_WIDTH  word address
write_enable  in  1  store when control=0; ignored otherwise
write_data  in  DATA_WIDTH  store/push data
privilege_mode_flag  in  1  1 = privileged mode
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
read_data  out  DATA_WIDTH  load/pop data; 0 on writes and faults
fault  out  1  response is a fault
fault_code  out  2  0 none, 1 code-area write, 2 privilege/stack violation, 3 out of range/reserved

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE
  - req_ready=1, resp_valid=0, read_data=0, fault=0, fault_code=0
  - RAM contents are not reset.
- FSM states: IDLE -> ACCESS -> RESPOND -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, register control, address, write_enable, write_data and privilege_mode_flag; go to ACCESS.
  - Later changes on the inputs have no effect on the captured request.
- ACCESS:
  - req_ready=0; evaluate the fault checks on the registered request.
  - Fault priority (highest first):
    - 3: control=3, or address >= DATA_AREA_SIZE.
    - 2: push/pop with address outside the active stack. Privileged stack is [4096,6144); user stack is [6144,8192).
    - 2: any access with privilege_mode_flag=0 and address inside the privileged stack.
    - 1: store or push with address < CODE_AREA_SIZE.
  - No fault:
    - Store/push: write the RAM on the clock edge leaving ACCESS.
    - Load/pop: synchronous RAM read into read_data on that edge.
  - Fault: no RAM write; read_data=0.
  - Go to RESPOND.
- RESPOND:
  - resp_valid=1; read_data, fault and fault_code stay stable until resp_ready=1.
  - On resp_valid & resp_ready, go to IDLE; resp_valid drops the next cycle.
- Latency and throughput:
  - Request accept to resp_valid is 2 cycles.
  - Minimum 3 cycles per transaction; no overlap of requests.
- Loads from the code area are permitted and are not a fault.
- A store with write_enable=0 and control=0 is a load.
- Reset asserted during ACCESS suppresses the pending write. Reset in RESPOND drops the response without handshake.
- resp_ready asserted while not in RESPOND is ignored.

Optional Feature:
- Macro: STACK_MEMORY_RESPONDER_FAULT_LATCH_EN.
- When defined:
  - Add outputs fault_sticky (1 bit) and fault_address (ADDR_WIDTH).
  - On the first faulting transaction after reset, latch address and set fault_sticky=1.
  - Later faults do not overwrite the latch; only reset clears it (both outputs 0).
- When undefined: ports absent; no latch logic.

Test Plan:
- Reset, then user-mode push addr 6200 data 0xDEADBEEF, then pop addr 6200 -> pop response read_data=0xDEADBEEF, fault=0; resp_valid 2 cycles after each accept.
- User-mode load addr 4500 -> fault=1, fault_code=2, read_data=0. Privileged-mode load addr 4500 after privileged push 0x12345678 -> read_data=0x12345678, fault=0.
- Store addr 100 data 0x55 -> fault_code=1. Subsequent load addr 100 returns the prior value, showing no write occurred.
- Load addr 8192 -> fault_code=3. Request with control=3, addr 5000 -> fault_code=3. Privileged push to addr 100 -> fault_code=2, because the stack check outranks the code-area check.
- Hold resp_ready=0 for 5 cycles in RESPOND -> resp_valid and read_data stable, req_ready=0 throughout. Toggle req_valid meanwhile -> no new capture.
- Assert reset during ACCESS of a store to addr 7000 -> no response; a later load addr 7000 returns the old value. With the latch macro: two faults (addr 9000 then 100) -> fault_address=9000, fault_sticky=1 until reset.
